// File: rtl/event_trigger_select_pkg.sv
`default_nettype none
// ============================================================================
// Package     : event_trigger_pkg
// Description : Shared definitions for the event trigger selector. Holds the
//               config opcodes, the FSM state encoding, the cfgData field
//               positions and the state-entry helper used after a select or
//               re-arm write.
// Ports       : none (package)
// Options     : EVENT_TRIGGER_COUNT_EN (consumed by the interface and top)
// Revision    : 1.0  initial release
// ============================================================================
package event_trigger_pkg;

  // Config opcodes carried in cfgData[31:30]
  localparam logic [1:0] OP_SELECT   = 2'd0;
  localparam logic [1:0] OP_PRESCALE = 2'd1;
  localparam logic [1:0] OP_HOLDOFF  = 2'd2;
  localparam logic [1:0] OP_REARM    = 2'd3;

  // cfgData field positions
  localparam int CFG_OP_MSB      = 31;
  localparam int CFG_OP_LSB      = 30;
  localparam int CFG_CODE_LSB    = 0;
  localparam int CFG_ENABLE_BIT  = 8;
  localparam int CFG_HBALIGN_BIT = 9;
  localparam int CFG_VALUE_LSB   = 0;

  typedef enum logic [1:0] {
    S_DISABLED = 2'd0,
    S_WAIT_HB  = 2'd1,
    S_ARMED    = 2'd2,
    S_HOLDOFF  = 2'd3
  } state_t;

  // State entered after a select or re-arm write.
  function automatic state_t entry_state(input logic enable, input logic hbAlign);
    state_t s;
    if (!enable) begin
      s = S_DISABLED;
    end else if (hbAlign) begin
      s = S_WAIT_HB;
    end else begin
      s = S_ARMED;
    end
    return s;
  endfunction

endpackage : event_trigger_pkg
`default_nettype wire

// File: rtl/event_trigger_select_if.sv
`default_nettype none
// ============================================================================
// Interface   : event_trigger_select_if
// Description : Event stream, config bus and trigger outputs of the event
//               trigger selector, bundled for a single-port hookup.
// Signals     : evrCode/evrCodeValid  decoded event code stream
//               evrHBstrobe           heartbeat strobe
//               cfgStrobe/cfgData     synchronised config write
//               triggerStrobe/armed   outputs to the pulse driver
//               triggerCount          only with EVENT_TRIGGER_COUNT_EN
// Modports    : master (stimulus side), slave (event_trigger_select)
// Options     : EVENT_TRIGGER_COUNT_EN adds triggerCount and COUNT_WIDTH
// Revision    : 1.0  initial release
// ============================================================================
interface event_trigger_select_if #(
  parameter int EVCODE_WIDTH = 8
`ifdef EVENT_TRIGGER_COUNT_EN
  , parameter int COUNT_WIDTH = 32
`endif
);

  logic [EVCODE_WIDTH-1:0] evrCode;
  logic                    evrCodeValid;
  logic                    evrHBstrobe;
  logic                    cfgStrobe;
  logic [31:0]             cfgData;
  logic                    triggerStrobe;
  logic                    armed;
`ifdef EVENT_TRIGGER_COUNT_EN
  logic [COUNT_WIDTH-1:0]  triggerCount;
`endif

  modport master (
    output evrCode,
    output evrCodeValid,
    output evrHBstrobe,
    output cfgStrobe,
    output cfgData,
    input  triggerStrobe,
    input  armed
`ifdef EVENT_TRIGGER_COUNT_EN
    , input triggerCount
`endif
  );

  modport slave (
    input  evrCode,
    input  evrCodeValid,
    input  evrHBstrobe,
    input  cfgStrobe,
    input  cfgData,
    output triggerStrobe,
    output armed
`ifdef EVENT_TRIGGER_COUNT_EN
    , output triggerCount
`endif
  );

endinterface : event_trigger_select_if
`default_nettype wire

// File: rtl/event_trigger_select_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : event_trigger_prescaler
// Description : Match prescaler. Fires on every (N+1)th qualified match,
//               where N is the prescale value captured at the last reload.
// Ports       : evrClk      clock
//               evrReset    synchronous active-high reset
//               load_i      reload count from prescale_i (select/re-arm)
//               match_i     qualified match (armed, no config write)
//               prescale_i  current prescale setting
//               fire_o      this match fires the trigger
// Revision    : 1.0  initial release
// ============================================================================
module event_trigger_prescaler #(
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                      evrClk,
  input  logic                      evrReset,
  input  logic                      load_i,
  input  logic                      match_i,
  input  logic [PRESCALE_WIDTH-1:0] prescale_i,
  output logic                      fire_o
);

  logic [PRESCALE_WIDTH-1:0] count_q;
  logic [PRESCALE_WIDTH-1:0] count_d;

  assign fire_o = match_i && (count_q == '0);

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = prescale_i;
    end else if (match_i) begin
      // Reload on fire so the next prescale setting takes effect here.
      if (count_q == '0) begin
        count_d = prescale_i;
      end else begin
        count_d = count_q - PRESCALE_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge evrClk) begin
    if (evrReset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule : event_trigger_prescaler
`default_nettype wire

// File: rtl/event_trigger_select.sv
`default_nettype none
// ============================================================================
// Module      : event_trigger_select
// Description : Matches one programmable event code in the decoded EVR
//               stream and issues a single-cycle triggerStrobe after prescale,
//               holdoff and optional heartbeat alignment. Config writes are
//               already in the evrClk domain.
// Ports       : evrClk    EVR parallel clock (sole clock)
//               evrReset  synchronous active-high reset
//               bus       event_trigger_select_if.slave: evrCode,
//                         evrCodeValid, evrHBstrobe, cfgStrobe, cfgData in;
//                         triggerStrobe, armed (, triggerCount) out
// Options     : EVENT_TRIGGER_COUNT_EN adds a saturating triggerCount
// Revision    : 1.0  initial release
// ============================================================================
module event_trigger_select
  import event_trigger_pkg::*;
#(
  parameter int EVCODE_WIDTH   = 8,
  parameter int PRESCALE_WIDTH = 16,
  parameter int HOLDOFF_WIDTH  = 20
`ifdef EVENT_TRIGGER_COUNT_EN
  , parameter int COUNT_WIDTH  = 32
`endif
) (
  input  logic                   evrClk,
  input  logic                   evrReset,
  event_trigger_select_if.slave  bus
);

  // --------------------------------------------------------------------------
  // Config decode and registers
  // --------------------------------------------------------------------------
  logic [1:0] w_op;
  logic       w_cfgSelect;
  logic       w_cfgRearm;
  logic       w_reload;
  logic       w_unused_cfg;

  assign w_op        = bus.cfgData[CFG_OP_MSB:CFG_OP_LSB];
  assign w_cfgSelect = bus.cfgStrobe && (w_op == OP_SELECT);
  assign w_cfgRearm  = bus.cfgStrobe && (w_op == OP_REARM);
  assign w_reload    = w_cfgSelect || w_cfgRearm;
  assign w_unused_cfg = ^bus.cfgData[CFG_OP_LSB-1:HOLDOFF_WIDTH];

  logic [EVCODE_WIDTH-1:0]   eventCode_q;
  logic                      enable_q;
  logic                      hbAlign_q;
  logic [PRESCALE_WIDTH-1:0] prescale_q;
  logic [HOLDOFF_WIDTH-1:0]  holdoff_q;

  always_ff @(posedge evrClk) begin
    if (evrReset) begin
      eventCode_q <= '0;
      enable_q    <= 1'b0;
      hbAlign_q   <= 1'b0;
      prescale_q  <= '0;
      holdoff_q   <= '0;
    end else if (bus.cfgStrobe) begin
      unique case (w_op)
        OP_SELECT: begin
          eventCode_q <= bus.cfgData[CFG_CODE_LSB +: EVCODE_WIDTH];
          enable_q    <= bus.cfgData[CFG_ENABLE_BIT];
          hbAlign_q   <= bus.cfgData[CFG_HBALIGN_BIT];
        end
        OP_PRESCALE: prescale_q <= bus.cfgData[CFG_VALUE_LSB +: PRESCALE_WIDTH];
        OP_HOLDOFF:  holdoff_q  <= bus.cfgData[CFG_VALUE_LSB +: HOLDOFF_WIDTH];
        default: ;
      endcase
    end
  end

  // A select write decides the entry state from the incoming bits; a re-arm
  // write reuses the stored enable/hbAlign.
  state_t w_entryState;
  assign w_entryState = entry_state(
    w_cfgSelect ? bus.cfgData[CFG_ENABLE_BIT]  : enable_q,
    w_cfgSelect ? bus.cfgData[CFG_HBALIGN_BIT] : hbAlign_q);

  // --------------------------------------------------------------------------
  // Match qualification and prescaler
  // --------------------------------------------------------------------------
  state_t state_q;
  state_t state_d;
  logic   w_match;
  logic   w_matchArmed;
  logic   w_fire;

  // Code 0 is reserved and never matches.
  assign w_match = bus.evrCodeValid && (bus.evrCode == eventCode_q)
                   && (eventCode_q != '0);

  // Any config write in the same cycle takes precedence over a match.
  assign w_matchArmed = w_match && (state_q == S_ARMED) && !bus.cfgStrobe;

  event_trigger_prescaler #(
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_prescaler (
    .evrClk     (evrClk),
    .evrReset   (evrReset),
    .load_i     (w_reload),
    .match_i    (w_matchArmed),
    .prescale_i (prescale_q),
    .fire_o     (w_fire)
  );

  // --------------------------------------------------------------------------
  // Trigger FSM
  // --------------------------------------------------------------------------
  logic [HOLDOFF_WIDTH-1:0] holdoffCount_q;
  logic [HOLDOFF_WIDTH-1:0] holdoffCount_d;
  logic                     triggerStrobe_q;

  always_comb begin
    state_d        = state_q;
    holdoffCount_d = holdoffCount_q;

    unique case (state_q)
      S_DISABLED: ;
      S_WAIT_HB: begin
        if (bus.evrHBstrobe) begin
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        // holdoff-1 makes the block deaf for exactly holdoff cycles.
        if (w_fire && (holdoff_q != '0)) begin
          state_d        = S_HOLDOFF;
          holdoffCount_d = holdoff_q - HOLDOFF_WIDTH'(1);
        end
      end
      S_HOLDOFF: begin
        if (holdoffCount_q == '0) begin
          state_d = S_ARMED;
        end else begin
          holdoffCount_d = holdoffCount_q - HOLDOFF_WIDTH'(1);
        end
      end
      default: state_d = S_DISABLED;
    endcase

    // Select/re-arm aborts holdoff and restarts from the entry state.
    if (w_reload) begin
      state_d        = w_entryState;
      holdoffCount_d = '0;
    end
  end

  always_ff @(posedge evrClk) begin
    if (evrReset) begin
      state_q         <= S_DISABLED;
      holdoffCount_q  <= '0;
      triggerStrobe_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      holdoffCount_q  <= holdoffCount_d;
      triggerStrobe_q <= w_fire;
    end
  end

  assign bus.triggerStrobe = triggerStrobe_q;
  assign bus.armed         = (state_q == S_ARMED);

  // --------------------------------------------------------------------------
  // Optional trigger counter
  // --------------------------------------------------------------------------
`ifdef EVENT_TRIGGER_COUNT_EN
  logic [COUNT_WIDTH-1:0] triggerCount_q;

  // Counts alongside the strobe register; a fire never coincides with a
  // re-arm because config writes block matches.
  always_ff @(posedge evrClk) begin
    if (evrReset || w_cfgRearm) begin
      triggerCount_q <= '0;
    end else if (w_fire && (triggerCount_q != '1)) begin
      triggerCount_q <= triggerCount_q + COUNT_WIDTH'(1);
    end
  end

  assign bus.triggerCount = triggerCount_q;
`endif

endmodule : event_trigger_select
`default_nettype wire
